// File: rtl/sdr_init_rfsh_ctrl.sv
// rtl/sdr_init_rfsh_ctrl.sv - SDRAM power-up init sequencer and periodic auto-refresh scheduler
`timescale 1ns/1ps
module sdr_init_rfsh_ctrl #(
  parameter logic [12:0] SDR_MODE      = 13'h033,
  parameter int          INIT_WAIT_CYC = 10000,
  parameter int          TRP           = 2,
  parameter int          TRFC          = 7,
  parameter int          TMRD          = 2,
  parameter int          RFSH_PERIOD   = 780,
  parameter int          PEND_MAX      = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        cfg_rfsh_en,
  input  logic        rfsh_gnt,
  output logic        rfsh_req,
  output logic        rfsh_urgent,
  output logic        rfsh_ovf,
  output logic        init_done,
  output logic        cmd_own,
  output logic [3:0]  sdr_cmd,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_cke
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  // Wait counter must hold the longest reload (the power-up wait).
  localparam int CW = $clog2(INIT_WAIT_CYC + TRP + 2 * TRFC + TMRD + 2);
  localparam int TW = $clog2(RFSH_PERIOD);
  localparam int PW = $clog2(PEND_MAX + 1);

  // State names the command currently on the bus (RF_CMD = AUTO_REFRESH being driven).
  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_RF1, S_INIT_RF2, S_INIT_MRS, S_IDLE, S_RF_CMD, S_RF_WAIT
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   timer, timer_n;
  logic [PW-1:0]   pend, pend_n;
  logic [3:0]      cmd_n;
  logic [12:0]     addr_n;
  logic            own_n, done_n, req_n, urgent_n, ovf_n;
  logic            expire, issue;

  assign sdr_ba = 2'b00;

  // Refresh interval timer: free-runs 0..RFSH_PERIOD-1 only after init with refresh enabled.
  always_comb begin
    expire  = init_done && cfg_rfsh_en && (timer == TW'(RFSH_PERIOD - 1));
    timer_n = '0;
    if (init_done && cfg_rfsh_en && !expire) timer_n = timer + 1'b1;
  end

  // Next-state, next-output and pending-count logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cmd_n   = CMD_NOP;
    addr_n  = '0;
    own_n   = cmd_own;
    done_n  = init_done;
    issue   = 1'b0;
    case (state)
      S_INIT_WAIT: begin
        own_n = 1'b1;
        if (cnt == '0) begin
          cmd_n   = CMD_PRE;
          addr_n  = 13'h0400;
          state_n = S_INIT_PRE;
          cnt_n   = CW'(TRP - 1);
        end else cnt_n = cnt - 1'b1;
      end
      S_INIT_PRE: begin
        if (cnt == '0) begin
          cmd_n   = CMD_REF;
          state_n = S_INIT_RF1;
          cnt_n   = CW'(TRFC - 1);
        end else cnt_n = cnt - 1'b1;
      end
      S_INIT_RF1: begin
        if (cnt == '0) begin
          cmd_n   = CMD_REF;
          state_n = S_INIT_RF2;
          cnt_n   = CW'(TRFC - 1);
        end else cnt_n = cnt - 1'b1;
      end
      S_INIT_RF2: begin
        if (cnt == '0) begin
          cmd_n   = CMD_MRS;
          addr_n  = SDR_MODE;
          state_n = S_INIT_MRS;
          cnt_n   = CW'(TMRD - 1);
        end else cnt_n = cnt - 1'b1;
      end
      S_INIT_MRS: begin
        if (cnt == '0) begin
          done_n  = 1'b1;
          own_n   = 1'b0;
          state_n = S_IDLE;
        end else cnt_n = cnt - 1'b1;
      end
      S_IDLE: begin
        // Grant only counts while our registered request is visible to the engine.
        if (rfsh_req && rfsh_gnt) begin
          cmd_n   = CMD_REF;
          own_n   = 1'b1;
          issue   = 1'b1;
          state_n = S_RF_CMD;
        end
      end
      S_RF_CMD: begin
        if (TRFC == 1) begin
          own_n   = 1'b0;
          state_n = S_IDLE;
        end else begin
          state_n = S_RF_WAIT;
          cnt_n   = CW'(TRFC - 2);
        end
      end
      default: begin
        if (cnt == '0) begin
          own_n   = 1'b0;
          state_n = S_IDLE;
        end else cnt_n = cnt - 1'b1;
      end
    endcase

    pend_n = pend;
    if (expire && !issue) begin
      if (pend != PW'(PEND_MAX)) pend_n = pend + 1'b1;
    end else if (issue && !expire) begin
      pend_n = pend - 1'b1;
    end
    ovf_n    = rfsh_ovf | (expire && (pend == PW'(PEND_MAX)));
    req_n    = (state_n == S_IDLE) && (pend_n != '0);
    urgent_n = (pend_n >= PW'(PEND_MAX / 2));
  end

  // All state and registered outputs; reset restarts initialisation.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state       <= S_INIT_WAIT;
      cnt         <= CW'(INIT_WAIT_CYC);
      timer       <= '0;
      pend        <= '0;
      sdr_cke     <= 1'b0;
      sdr_cmd     <= CMD_NOP;
      sdr_addr    <= '0;
      cmd_own     <= 1'b0;
      init_done   <= 1'b0;
      rfsh_req    <= 1'b0;
      rfsh_urgent <= 1'b0;
      rfsh_ovf    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      timer       <= timer_n;
      pend        <= pend_n;
      sdr_cke     <= 1'b1;
      sdr_cmd     <= cmd_n;
      sdr_addr    <= addr_n;
      cmd_own     <= own_n;
      init_done   <= done_n;
      rfsh_req    <= req_n;
      rfsh_urgent <= urgent_n;
      rfsh_ovf    <= ovf_n;
    end
  end

endmodule

// File: tb/tb_sdr_init_rfsh_ctrl.sv
// tb/tb_sdr_init_rfsh_ctrl.sv - scoreboard bench for sdr_init_rfsh_ctrl
`timescale 1ns/1ps
module tb_sdr_init_rfsh_ctrl;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam int TRFC = 7;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        gnt = 1'b0;
  logic        rfsh_req, rfsh_urgent, rfsh_ovf, init_done, cmd_own, sdr_cke;
  logic [3:0]  sdr_cmd;
  logic [12:0] sdr_addr;
  logic [1:0]  sdr_ba;

  typedef struct packed {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc;
  int   n_checks = 0;
  int   n_pass = 0;
  int   base;

  sdr_init_rfsh_ctrl #(
    .SDR_MODE(13'h033), .INIT_WAIT_CYC(8), .TRP(2), .TRFC(TRFC), .TMRD(2),
    .RFSH_PERIOD(20), .PEND_MAX(8)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(rstn), .cfg_rfsh_en(en), .rfsh_gnt(gnt),
    .rfsh_req(rfsh_req), .rfsh_urgent(rfsh_urgent), .rfsh_ovf(rfsh_ovf),
    .init_done(init_done), .cmd_own(cmd_own), .sdr_cmd(sdr_cmd),
    .sdr_addr(sdr_addr), .sdr_ba(sdr_ba), .sdr_cke(sdr_cke)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Cycle index: 0 is the first rising edge with reset released.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= -1;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic at_cycle(input int k);
    int guard = 0;
    while (cyc < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("at_cycle_timeout", 32'(cyc), 32'(k));
  endtask

  task automatic push(input int c, input logic [3:0] cmd, input logic [12:0] addr);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic push_init();
    push(8, CMD_PRE, 13'h0400);
    push(10, CMD_REF, 13'h0);
    push(17, CMD_REF, 13'h0);
    push(24, CMD_MRS, 13'h033);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cke"}, 32'(sdr_cke), 0);
    check({tag, "_cmd"}, 32'(sdr_cmd), 32'(CMD_NOP));
    check({tag, "_addr"}, 32'(sdr_addr), 0);
    check({tag, "_ba"}, 32'(sdr_ba), 0);
    check({tag, "_own"}, 32'(cmd_own), 0);
    check({tag, "_req"}, 32'(rfsh_req), 0);
    check({tag, "_urgent"}, 32'(rfsh_urgent), 0);
    check({tag, "_ovf"}, 32'(rfsh_ovf), 0);
    check({tag, "_done"}, 32'(init_done), 0);
  endtask

  // Every non-NOP command must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && sdr_cmd !== CMD_NOP) begin
      if (sb.size() == 0) check("unexpected_cmd", 32'(sdr_cmd), 32'(CMD_NOP));
      else begin
        mon_e = sb.pop_front();
        check("cmd", 32'(sdr_cmd), 32'(mon_e.cmd));
        check("cmd_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("cmd_addr", 32'(sdr_addr), 32'(mon_e.addr));
        check("cmd_ba", 32'(sdr_ba), 0);
        check("own_at_cmd", 32'(cmd_own), 1);
      end
    end
  end

  initial begin
    en = 1'b1; gnt = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");

    // Init timeline and first refresh with grant tied high.
    push_init();
    push(47, CMD_REF, 13'h0);
    rstn = 1'b1;
    at_cycle(0);  check("c0_cke", 32'(sdr_cke), 1); check("c0_own", 32'(cmd_own), 1);
    at_cycle(25); check("c25_done", 32'(init_done), 0); check("c25_own", 32'(cmd_own), 1);
    at_cycle(26); check("c26_done", 32'(init_done), 1); check("c26_own", 32'(cmd_own), 0);
    at_cycle(45); check("c45_req", 32'(rfsh_req), 0);
    at_cycle(46); check("c46_req", 32'(rfsh_req), 1);
    at_cycle(47); check("c47_req", 32'(rfsh_req), 0);
    at_cycle(53); check("c53_own", 32'(cmd_own), 1);
    at_cycle(54); check("c54_own", 32'(cmd_own), 0); check("c54_req", 32'(rfsh_req), 0);
    gnt = 1'b0;

    // Expiry on the same edge as an issue: pend stays 1, request returns after the window.
    at_cycle(66); check("c66_req", 32'(rfsh_req), 1);
    push(86, CMD_REF, 13'h0);
    push(94, CMD_REF, 13'h0);
    at_cycle(85); gnt = 1'b1;
    at_cycle(92); check("c92_own", 32'(cmd_own), 1); check("c92_req", 32'(rfsh_req), 0);
    at_cycle(93); check("c93_own", 32'(cmd_own), 0); check("c93_req", 32'(rfsh_req), 1);
    at_cycle(94); en = 1'b0; gnt = 1'b0;
    at_cycle(101); check("c101_own", 32'(cmd_own), 0); check("c101_req", 32'(rfsh_req), 0);

    // Refresh disabled: grant pulses must not produce requests or commands.
    for (int i = 0; i < 100; i++) begin
      gnt = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (i % 10 == 0) check("gate_req", 32'(rfsh_req), 0);
    end
    gnt = 1'b0;

    // Backlog with no grant: saturation at 8 and overflow on the 9th expiry.
    base = cyc;
    en = 1'b1;
    at_cycle(base + 79);  check("bl_urg_pre", 32'(rfsh_urgent), 0);
    at_cycle(base + 80);  check("bl_urg", 32'(rfsh_urgent), 1); check("bl_req", 32'(rfsh_req), 1);
    at_cycle(base + 160); check("bl_ovf8", 32'(rfsh_ovf), 0);
    at_cycle(base + 179); check("bl_ovf_pre", 32'(rfsh_ovf), 0);
    at_cycle(base + 180); check("bl_ovf9", 32'(rfsh_ovf), 1);
    at_cycle(base + 185);
    for (int i = 0; i < 8; i++) push(base + 186 + i * (TRFC + 1), CMD_REF, 13'h0);
    en = 1'b0; gnt = 1'b1;
    at_cycle(base + 250);
    check("drain_req", 32'(rfsh_req), 0);
    check("drain_urg", 32'(rfsh_urgent), 0);
    check("drain_ovf", 32'(rfsh_ovf), 1);
    check("drain_own", 32'(cmd_own), 0);
    check("drain_sb", 32'(sb.size()), 0);

    // Asynchronous reset during INIT_RF2.
    rstn = 1'b0; #1;
    check_reset_vals("rst_idle");
    repeat (3) @(negedge clk);
    push(8, CMD_PRE, 13'h0400);
    push(10, CMD_REF, 13'h0);
    push(17, CMD_REF, 13'h0);
    en = 1'b1; gnt = 1'b1;
    rstn = 1'b1;
    at_cycle(20);
    rstn = 1'b0; #1;
    check_reset_vals("rst_rf2");
    check("rst_rf2_sb", 32'(sb.size()), 0);

    // Restart and assert reset again during RF_WAIT.
    repeat (3) @(negedge clk);
    push_init();
    push(47, CMD_REF, 13'h0);
    rstn = 1'b1;
    at_cycle(26); check("re1_done", 32'(init_done), 1);
    at_cycle(50); check("re1_own", 32'(cmd_own), 1);
    rstn = 1'b0; #1;
    check_reset_vals("rst_rfwait");

    // Init restarts from cycle 0 after release.
    repeat (3) @(negedge clk);
    push_init();
    rstn = 1'b1;
    at_cycle(0);  check("re2_cke", 32'(sdr_cke), 1);
    at_cycle(26); check("re2_done", 32'(init_done), 1); check("re2_own", 32'(cmd_own), 0);
    at_cycle(30);
    check("final_sb", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
